// File: rtl/clz_denorm_pkg.sv
// Shared helpers for the clz denormalizer pipeline.
package clz_denorm_pkg;

  // Widest shift count the pipeline supports (ORDER = 6 -> 7 bits).
  localparam int unsigned MaxCountW = 7;

  // OR of count bits strictly below position n.
  function automatic logic any_below(input logic [MaxCountW-1:0] count, input int unsigned n);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < MaxCountW; i++) begin
      if (i < n) r = r | count[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/clz_denorm_stage.sv
// One registered denormalize stage: conditional right shift by SHIFT with valid/ready load.
// With SHIFT == W the shift zeroes the word and the stage also flags counts above W.
module clz_denorm_stage
  import clz_denorm_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned SHIFT = 1,
  parameter int unsigned CW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prev_valid,
  input  logic [W-1:0]  prev_data,
  input  logic [CW-1:0] prev_count,
  input  logic          prev_err,
  input  logic          next_load,
  output logic          load,
  output logic          valid,
  output logic [W-1:0]  data,
  output logic [CW-1:0] count,
  output logic          err
);

  localparam int unsigned Bit   = $clog2(SHIFT);
  localparam bit          Final = (SHIFT == W);

  logic          valid_q, err_q, err_d;
  logic [W-1:0]  data_q, data_d;
  logic [CW-1:0] count_q;

  assign load = !valid_q || next_load;

  always_comb begin
    data_d = prev_data;
    if (prev_count[Bit]) data_d = prev_data >> SHIFT;
    err_d = prev_err;
    if (Final) begin
      err_d = prev_err | (prev_count[Bit] & any_below(MaxCountW'(prev_count), Bit));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (load) begin
      valid_q <= prev_valid;
      data_q  <= data_d;
      count_q <= prev_count;
      err_q   <= err_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign count = count_q;
  assign err   = err_q;

endmodule

// File: rtl/clz_denorm.sv
// Pipelined denormalizer: right-shifts a left-justified word by its leading-zero count.
// ORDER shift stages plus a final zero/err stage; ready chains combinationally from out_ready.
module clz_denorm
  import clz_denorm_pkg::*;
#(
  parameter int unsigned ORDER = 3,
  localparam int unsigned W    = 2 ** ORDER
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic [ORDER:0] in_count,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           out_err
);

  localparam int unsigned NS = ORDER + 1;
  localparam int unsigned CW = ORDER + 1;

  logic          valid_c [NS+1];
  logic          load_c  [NS+1];
  logic          err_c   [NS+1];
  logic [W-1:0]  data_c  [NS+1];
  logic [CW-1:0] count_c [NS+1];
  logic          unused_count;

  assign valid_c[0] = in_valid;
  assign data_c[0]  = in_data;
  assign count_c[0] = in_count;
  assign err_c[0]   = 1'b0;
  assign load_c[NS] = out_ready;

  // Stage k shifts by 2**k; the last (k == ORDER) shifts by W, i.e. zeroes the word.
  for (genvar k = 0; k < NS; k++) begin : gen_stage
    clz_denorm_stage #(
      .W     (W),
      .SHIFT (2 ** k),
      .CW    (CW)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .prev_valid (valid_c[k]),
      .prev_data  (data_c[k]),
      .prev_count (count_c[k]),
      .prev_err   (err_c[k]),
      .next_load  (load_c[k+1]),
      .load       (load_c[k]),
      .valid      (valid_c[k+1]),
      .data       (data_c[k+1]),
      .count      (count_c[k+1]),
      .err        (err_c[k+1])
    );
  end

  assign in_ready     = load_c[0];
  assign out_valid    = valid_c[NS];
  assign out_data     = data_c[NS];
  assign out_err      = err_c[NS];
  assign unused_count = ^count_c[NS];

endmodule
